g10_xgmii_width_bridge: RTL and testbench



---
 rtl/g10_xgmii_pkg.sv | 43 ++++
 rtl/xgmii_rx_32to64.sv | 61 ++++++
 rtl/g10_xgmii_width_bridge.sv | 120 ++++++++++++
 tb/tb_g10_xgmii_width_bridge.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/g10_xgmii_pkg.sv
// Shared XGMII definitions for the 10GBASE-R / PMA width bridge:
// control characters, lane geometry, data/control bundles and the TX half counter.
package g10_xgmii_pkg;

    localparam int LANE_W      = 8;
    localparam int BASER_LANES = 8;
    localparam int PMA_LANES   = 4;
    localparam int BASER_W     = BASER_LANES * LANE_W;
    localparam int PMA_W       = PMA_LANES * LANE_W;

    localparam logic [LANE_W-1:0] XGMII_IDLE  = 8'h07;
    localparam logic [LANE_W-1:0] XGMII_START = 8'hFB;
    localparam logic [LANE_W-1:0] XGMII_TERM  = 8'hFD;
    localparam logic [LANE_W-1:0] XGMII_ERR   = 8'hFE;

    // 64-bit baser word: data plus one control flag per lane.
    typedef struct packed {
        logic [BASER_W-1:0]     d;
        logic [BASER_LANES-1:0] c;
    } xgmii64_t;

    // 32-bit PMA word: data plus one control flag per lane.
    typedef struct packed {
        logic [PMA_W-1:0]     d;
        logic [PMA_LANES-1:0] c;
    } xgmii32_t;

    localparam xgmii32_t XGMII32_IDLE = '{d: {PMA_LANES{XGMII_IDLE}},   c: {PMA_LANES{1'b1}}};
    localparam xgmii64_t XGMII64_IDLE = '{d: {BASER_LANES{XGMII_IDLE}}, c: {BASER_LANES{1'b1}}};

    // Number of 32-bit halves of the held TX word still to be sent.
    typedef enum logic [1:0] {
        TX_EMPTY = 2'd0,
        TX_UPPER = 2'd1,
        TX_LOWER = 2'd2
    } tx_cnt_e;

    // A PMA word opens a frame in lane 0.
    function automatic logic is_start_lane0(input xgmii32_t w);
        return w.c[0] && (w.d[LANE_W-1:0] == XGMII_START);
    endfunction

endpackage

// File: rtl/xgmii_rx_32to64.sv
// RX pairing of 32-bit PMA words into 64-bit baser words. A Start character
// in lane 0 of the second half forces the pending half out padded with Idle,
// so that every Start lands in lane 0 or lane 4 of the baser word.
module xgmii_rx_32to64
    import g10_xgmii_pkg::*;
(
    input  logic                   clk_ref,
    input  logic                   rst_ref,
    input  logic [PMA_W-1:0]       pma_rx_d,
    input  logic [PMA_LANES-1:0]   pma_rx_c,
    input  logic                   pma_rx_v,
    output logic [BASER_W-1:0]     baser_rx_d,
    output logic [BASER_LANES-1:0] baser_rx_c,
    output logic                   baser_rx_v
);

    xgmii32_t rx_word;
    xgmii32_t pend_word_q;
    logic     pend_q;
    xgmii64_t rx_out_q;
    logic     rx_v_q;

    assign rx_word = '{d: pma_rx_d, c: pma_rx_c};

    // Pair halves, realign on a lane-0 Start, and emit one-cycle baser pulses.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    // NOTE: the pending half and output word are reset as well, so a reset in
    // mid-frame cannot leak stale lanes into the first word after release.
    always_ff @(posedge clk_ref or negedge rst_ref) begin
        if (!rst_ref) begin
            pend_word_q <= XGMII32_IDLE;
            pend_q      <= 1'b0;
            rx_out_q    <= XGMII64_IDLE;
            rx_v_q      <= 1'b0;
        end else begin
            rx_v_q <= 1'b0;
            if (pma_rx_v) begin
                if (!pend_q) begin
                    pend_word_q <= rx_word;
                    pend_q      <= 1'b1;
                end else if (is_start_lane0(rx_word)) begin
                    rx_out_q    <= '{d: {XGMII32_IDLE.d, pend_word_q.d},
                                     c: {XGMII32_IDLE.c, pend_word_q.c}};
                    rx_v_q      <= 1'b1;
                    pend_word_q <= rx_word;
                end else begin
                    rx_out_q <= '{d: {rx_word.d, pend_word_q.d},
                                  c: {rx_word.c, pend_word_q.c}};
                    rx_v_q   <= 1'b1;
                    pend_q   <= 1'b0;
                end
            end
        end
    end

    assign baser_rx_d = rx_out_q.d;
    assign baser_rx_c = rx_out_q.c;
    assign baser_rx_v = rx_v_q;

endmodule

// File: rtl/g10_xgmii_width_bridge.sv
// Bidirectional XGMII width bridge between the 64-bit 10GBASE-R side and the
// 32-bit PMA side. TX splits each baser word into lower then upper halves;
// RX pairing/realignment lives in xgmii_rx_32to64.
module g10_xgmii_width_bridge
    import g10_xgmii_pkg::*;
#(
    parameter int XGMII_WIDTH_BASER = 64,
    parameter int XGMII_WIDTH_PMA   = 32
) (
    input  logic                           clk_ref,
    input  logic                           rst_ref,
    input  logic [XGMII_WIDTH_BASER-1:0]   baser_tx_d,
    input  logic [XGMII_WIDTH_BASER/8-1:0] baser_tx_c,
    input  logic                           baser_tx_v,
    output logic                           baser_tx_rdy,
    output logic [XGMII_WIDTH_PMA-1:0]     pma_tx_d,
    output logic [XGMII_WIDTH_PMA/8-1:0]   pma_tx_c,
    output logic                           pma_tx_v,
    input  logic [XGMII_WIDTH_PMA-1:0]     pma_rx_d,
    input  logic [XGMII_WIDTH_PMA/8-1:0]   pma_rx_c,
    input  logic                           pma_rx_v,
    output logic [XGMII_WIDTH_BASER-1:0]   baser_rx_d,
    output logic [XGMII_WIDTH_BASER/8-1:0] baser_rx_c,
    output logic                           baser_rx_v
);

    tx_cnt_e  tx_cnt_q;
    tx_cnt_e  tx_cnt_d;
    xgmii64_t tx_hold_q;
    xgmii32_t tx_out_d;
    logic     tx_v_d;
    xgmii32_t tx_out_q;
    logic     tx_v_q;
    logic     tx_accept;

    // A new word may be taken while the upper half of the previous one is
    // going out, which keeps the PMA side busy every cycle when streaming.
    assign baser_tx_rdy = (tx_cnt_q != TX_LOWER);
    assign tx_accept    = baser_tx_v && baser_tx_rdy;

    // Half-counter state register.
    always_ff @(posedge clk_ref or negedge rst_ref) begin
        if (!rst_ref) begin
            tx_cnt_q <= TX_EMPTY;
        end else begin
            tx_cnt_q <= tx_cnt_d;
        end
    end

    // Next half-counter value: accept reloads, otherwise count down to empty.
    always_comb begin
        // NOTE: default first so every path assigns and no latch is inferred.
        tx_cnt_d = TX_EMPTY;
        if (tx_accept) begin
            tx_cnt_d = TX_LOWER;
        end else begin
            case (tx_cnt_q)
                TX_LOWER: tx_cnt_d = TX_UPPER;
                TX_UPPER: tx_cnt_d = TX_EMPTY;
                default:  tx_cnt_d = TX_EMPTY;
            endcase
        end
    end

    // Half selection from the pre-update hold register and counter.
    always_comb begin
        tx_out_d = XGMII32_IDLE;
        tx_v_d   = 1'b0;
        case (tx_cnt_q)
            TX_LOWER: begin
                tx_out_d = '{d: tx_hold_q.d[PMA_W-1:0], c: tx_hold_q.c[PMA_LANES-1:0]};
                tx_v_d   = 1'b1;
            end
            TX_UPPER: begin
                tx_out_d = '{d: tx_hold_q.d[BASER_W-1:PMA_W], c: tx_hold_q.c[BASER_LANES-1:PMA_LANES]};
                tx_v_d   = 1'b1;
            end
            default: begin
                tx_out_d = XGMII32_IDLE;
                tx_v_d   = 1'b0;
            end
        endcase
    end

    // Hold register for the accepted baser word.
    always_ff @(posedge clk_ref or negedge rst_ref) begin
        if (!rst_ref) begin
            tx_hold_q <= XGMII64_IDLE;
        end else if (tx_accept) begin
            tx_hold_q <= '{d: baser_tx_d, c: baser_tx_c};
        end
    end

    // Registered PMA TX outputs.
    always_ff @(posedge clk_ref or negedge rst_ref) begin
        if (!rst_ref) begin
            tx_out_q <= XGMII32_IDLE;
            tx_v_q   <= 1'b0;
        end else begin
            tx_out_q <= tx_out_d;
            tx_v_q   <= tx_v_d;
        end
    end

    assign pma_tx_d = tx_out_q.d;
    assign pma_tx_c = tx_out_q.c;
    assign pma_tx_v = tx_v_q;

    xgmii_rx_32to64 u_rx (
        .clk_ref    (clk_ref),
        .rst_ref    (rst_ref),
        .pma_rx_d   (pma_rx_d),
        .pma_rx_c   (pma_rx_c),
        .pma_rx_v   (pma_rx_v),
        .baser_rx_d (baser_rx_d),
        .baser_rx_c (baser_rx_c),
        .baser_rx_v (baser_rx_v)
    );

endmodule

// File: tb/tb_g10_xgmii_width_bridge.sv
// Scoreboard bench for g10_xgmii_width_bridge: stimulus pushes expected PMA
// and baser words into queues, monitors pop and compare on every valid output.
module tb_g10_xgmii_width_bridge;

    logic        clk_ref;
    logic        rst_ref;
    logic [63:0] baser_tx_d;
    logic [7:0]  baser_tx_c;
    logic        baser_tx_v;
    logic        baser_tx_rdy;
    logic [31:0] pma_tx_d;
    logic [3:0]  pma_tx_c;
    logic        pma_tx_v;
    logic [31:0] pma_rx_d;
    logic [3:0]  pma_rx_c;
    logic        pma_rx_v;
    logic [63:0] baser_rx_d;
    logic [7:0]  baser_rx_c;
    logic        baser_rx_v;

    int tests;
    int fails;
    int tx_run;
    int tx_max_run;

    logic [35:0] tx_q[$];   // {c[3:0], d[31:0]}
    logic [71:0] rx_q[$];   // {c[7:0], d[63:0]}

    g10_xgmii_width_bridge dut (
        .clk_ref      (clk_ref),
        .rst_ref      (rst_ref),
        .baser_tx_d   (baser_tx_d),
        .baser_tx_c   (baser_tx_c),
        .baser_tx_v   (baser_tx_v),
        .baser_tx_rdy (baser_tx_rdy),
        .pma_tx_d     (pma_tx_d),
        .pma_tx_c     (pma_tx_c),
        .pma_tx_v     (pma_tx_v),
        .pma_rx_d     (pma_rx_d),
        .pma_rx_c     (pma_rx_c),
        .pma_rx_v     (pma_rx_v),
        .baser_rx_d   (baser_rx_d),
        .baser_rx_c   (baser_rx_c),
        .baser_rx_v   (baser_rx_v)
    );

    initial clk_ref = 1'b0;
    always #5 clk_ref = ~clk_ref;

    task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name, input logic [71:0] act);
        tests++;
        fails++;
        $display("FAIL %s: unexpected valid output %h", name, act);
    endtask

    // Monitor: compare every valid output against the scoreboard queues.
    always @(negedge clk_ref) begin
        if (rst_ref) begin
            if (pma_tx_v) begin
                if (tx_q.size() == 0) unexpected("pma_tx", {36'h0, pma_tx_c, pma_tx_d});
                else check("pma_tx", {36'h0, pma_tx_c, pma_tx_d}, {36'h0, tx_q.pop_front()});
                tx_run++;
                if (tx_run > tx_max_run) tx_max_run = tx_run;
            end else begin
                tx_run = 0;
            end
            if (baser_rx_v) begin
                if (rx_q.size() == 0) unexpected("baser_rx", {baser_rx_c, baser_rx_d});
                else check("baser_rx", {baser_rx_c, baser_rx_d}, rx_q.pop_front());
            end
        end else begin
            tx_run = 0;
        end
    end

    task automatic tick();
        @(posedge clk_ref);
        #1;
    endtask

    task automatic rx_word(input logic [31:0] d, input logic [3:0] c);
        pma_rx_d = d;
        pma_rx_c = c;
        pma_rx_v = 1'b1;
        tick();
        pma_rx_v = 1'b0;
    endtask

    task automatic push_tx_word(input logic [63:0] d, input logic [7:0] c);
        tx_q.push_back({c[3:0], d[31:0]});
        tx_q.push_back({c[7:4], d[63:32]});
    endtask

    logic [63:0] w_d [4];
    logic [7:0]  w_c [4];

    initial begin
        tests = 0;
        fails = 0;
        tx_run = 0;
        tx_max_run = 0;
        rst_ref = 1'b0;
        baser_tx_d = '0;
        baser_tx_c = '0;
        baser_tx_v = 1'b0;
        pma_rx_d = '0;
        pma_rx_c = '0;
        pma_rx_v = 1'b0;

        // Reset values.
        repeat (10) tick();
        check("rst_pma_tx_v",   {71'h0, pma_tx_v}, 72'h0);
        check("rst_pma_tx_dc",  {36'h0, pma_tx_c, pma_tx_d}, {36'h0, 4'hF, 32'h07070707});
        check("rst_baser_rx_v", {71'h0, baser_rx_v}, 72'h0);
        check("rst_baser_rx",   {baser_rx_c, baser_rx_d}, {8'hFF, 64'h0707070707070707});
        check("rst_tx_rdy",     {71'h0, baser_tx_rdy}, 72'h1);
        @(negedge clk_ref);
        rst_ref = 1'b1;
        tick();

        // Single TX word, then Idle.
        push_tx_word(64'h8877665544332211, 8'h00);
        baser_tx_d = 64'h8877665544332211;
        baser_tx_c = 8'h00;
        baser_tx_v = 1'b1;
        check("single_rdy", {71'h0, baser_tx_rdy}, 72'h1);
        tick();
        baser_tx_v = 1'b0;
        repeat (3) tick();
        check("single_idle_v",  {71'h0, pma_tx_v}, 72'h0);
        check("single_idle_dc", {36'h0, pma_tx_c, pma_tx_d}, {36'h0, 4'hF, 32'h07070707});

        // Streaming TX: rdy toggles, PMA side valid 8 cycles in a row.
        w_d[0] = 64'h0F0E0D0C0B0A0908; w_c[0] = 8'h00;
        w_d[1] = 64'h070707FD17161514; w_c[1] = 8'hF0;
        w_d[2] = 64'hD5555555555555FB; w_c[2] = 8'h01;
        w_d[3] = 64'hFE07070707070707; w_c[3] = 8'hFF;
        tx_max_run = 0;
        for (int j = 0; j < 8; j++) begin
            baser_tx_d = w_d[j/2];
            baser_tx_c = w_c[j/2];
            baser_tx_v = 1'b1;
            if (j % 2 == 0) push_tx_word(w_d[j/2], w_c[j/2]);
            check("stream_rdy", {71'h0, baser_tx_rdy}, {71'h0, (j % 2 == 0)});
            tick();
        end
        baser_tx_v = 1'b0;
        repeat (3) tick();
        check("stream_run", 72'(tx_max_run), 72'd8);
        check("stream_drained", 72'(tx_q.size()), 72'd0);

        // RX pairing.
        rx_word(32'h070707FB, 4'h1);
        rx_q.push_back({8'h01, 64'h44332211070707FB});
        rx_word(32'h44332211, 4'h0);

        // RX realignment with an invalid gap cycle before the Start.
        rx_word(32'h07070707, 4'hF);
        tick();
        rx_q.push_back({8'hFF, 64'h0707070707070707});
        rx_word(32'h555555FB, 4'h1);
        rx_q.push_back({8'h01, 64'hAABBCCDD555555FB});
        rx_word(32'hAABBCCDD, 4'h0);

        // Back-to-back pairs; 0xFB without its control flag is plain data.
        rx_q.push_back({8'hC0, 64'h0707FD0603020100});
        rx_q.push_back({8'h00, 64'h123456FB99999999});
        pma_rx_v = 1'b1;
        pma_rx_d = 32'h03020100; pma_rx_c = 4'h0; tick();
        pma_rx_d = 32'h0707FD06; pma_rx_c = 4'hC; tick();
        pma_rx_d = 32'h99999999; pma_rx_c = 4'h0; tick();
        pma_rx_d = 32'h123456FB; pma_rx_c = 4'h0; tick();
        pma_rx_v = 1'b0;

        // Pending Start followed by another Start.
        rx_word(32'h000000FB, 4'h1);
        rx_q.push_back({8'hF1, 64'h07070707000000FB});
        rx_word(32'h111111FB, 4'h1);
        rx_q.push_back({8'h01, 64'h22222222111111FB});
        rx_word(32'h22222222, 4'h0);
        repeat (3) tick();
        check("rx_drained", 72'(rx_q.size()), 72'd0);

        // Reset mid-frame: pend=1 on RX, cnt=1 on TX.
        rx_word(32'h12345678, 4'h0);
        tx_q.push_back({4'h0, 32'hCAFEF00D});
        baser_tx_d = 64'hDEADBEEFCAFEF00D;
        baser_tx_c = 8'h00;
        baser_tx_v = 1'b1;
        tick();
        baser_tx_v = 1'b0;
        tick();
        @(negedge clk_ref);
        #1;
        rst_ref = 1'b0;
        #1;
        check("midrst_pma_tx_v", {71'h0, pma_tx_v}, 72'h0);
        check("midrst_rdy",      {71'h0, baser_tx_rdy}, 72'h1);
        repeat (3) tick();
        @(negedge clk_ref);
        rst_ref = 1'b1;
        repeat (5) tick();
        check("post_rst_pma_tx_v",   {71'h0, pma_tx_v}, 72'h0);
        check("post_rst_baser_rx_v", {71'h0, baser_rx_v}, 72'h0);
        rx_word(32'hA1A2A3A4, 4'h0);
        tick();
        rx_q.push_back({8'h00, 64'hB1B2B3B4A1A2A3A4});
        rx_word(32'hB1B2B3B4, 4'h0);
        repeat (3) tick();
        check("final_tx_q", 72'(tx_q.size()), 72'd0);
        check("final_rx_q", 72'(rx_q.size()), 72'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

endmodule
